// File: rtl/iterative_divider.sv
// iterative_divider: restoring shift-and-subtract divider, one quotient bit per clock.
// Define ITERATIVE_DIVIDER_SIGNED_EN to honour signed_i (DIV); otherwise every operation is unsigned.
module iterative_divider #(
   parameter int width = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic [width-1:0] dividend_i,
   input  logic [width-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [width-1:0] quotient_o,
   output logic [width-1:0] remainder_o
);
   localparam int CW = $clog2(width);
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
   state_t           r_state, w_next;
   logic [CW-1:0]    r_cnt;
   logic [width-1:0] r_rem, r_quo, r_dvs, r_quotient, r_remainder;
   logic             r_div0;
   logic             w_accept;
   logic [width-1:0] w_dnd_mag, w_dvs_mag, w_q_fix, w_r_fix;
   logic [width:0]   w_shift, w_diff;
   assign w_accept = start_i && (r_state == IDLE || r_state == DONE);
   assign w_shift  = {r_rem, r_quo[width-1]};
   // Top bit of the width+1 difference is the borrow: set when the divisor does not fit.
   assign w_diff   = w_shift - {1'b0, r_dvs};
`ifdef ITERATIVE_DIVIDER_SIGNED_EN
   logic r_qneg, r_rneg, r_ovf;
   logic w_dnd_neg, w_dvs_neg, w_ovf;
   assign w_dnd_neg = signed_i & dividend_i[width-1];
   assign w_dvs_neg = signed_i & divisor_i[width-1];
   assign w_dnd_mag = w_dnd_neg ? -dividend_i : dividend_i;
   assign w_dvs_mag = w_dvs_neg ? -divisor_i : divisor_i;
   assign w_ovf     = w_dnd_neg && dividend_i[width-2:0] == '0 && divisor_i == '1;
   assign w_q_fix   = r_ovf ? {1'b1, {(width-1){1'b0}}} : r_qneg ? -r_quo : r_quo;
   assign w_r_fix   = r_ovf ? '0 : (r_rneg && r_rem != '0) ? -r_rem : r_rem;
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_qneg <= 1'b0;
         r_rneg <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (w_accept) begin
         r_qneg <= w_dnd_neg ^ w_dvs_neg;
         r_rneg <= w_dnd_neg;
         r_ovf  <= w_ovf;
      end
   end
`else
   logic w_unused_signed;
   assign w_unused_signed = signed_i;
   assign w_dnd_mag = dividend_i;
   assign w_dvs_mag = divisor_i;
   assign w_q_fix   = r_quo;
   assign w_r_fix   = r_rem;
`endif
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= IDLE;
      else        r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = start_i ? RUN : IDLE;
         RUN:     w_next = (r_cnt == '0) ? FIX : RUN;
         FIX:     w_next = DONE;
         DONE:    w_next = start_i ? RUN : IDLE;
         default: w_next = IDLE;
      endcase
   end
   // A zero divisor leaves the dividend magnitude in r_rem, so the sign fix restores the original dividend.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_dvs       <= '0;
         r_div0      <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
      end else if (w_accept) begin
         r_cnt  <= CW'(width - 1);
         r_rem  <= '0;
         r_quo  <= w_dnd_mag;
         r_dvs  <= w_dvs_mag;
         r_div0 <= divisor_i == '0;
      end else if (r_state == RUN) begin
         r_cnt <= r_cnt - 1'b1;
         r_rem <= w_diff[width] ? w_shift[width-1:0] : w_diff[width-1:0];
         r_quo <= {r_quo[width-2:0], ~w_diff[width]};
      end else if (r_state == FIX) begin
         r_quotient  <= r_div0 ? '1 : w_q_fix;
         r_remainder <= w_r_fix;
      end
   end
   assign busy_o      = r_state == RUN || r_state == FIX;
   assign done_o      = r_state == DONE;
   assign quotient_o  = r_quotient;
   assign remainder_o = r_remainder;
endmodule

// File: tb/tb_iterative_divider.sv
// tb_iterative_divider: directed divisions; a monitor checks each done_o against a queue of expected results.
module tb_iterative_divider;
   logic        clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0, signed_i = 1'b0;
   logic [31:0] dividend_i = '0, divisor_i = '0;
   logic        busy_o, done_o;
   logic [31:0] quotient_o, remainder_o;
   int          total = 0, bad = 0, cyc = 0;
   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          c;
      string       n;
   } exp_t;
   exp_t sb[$];

   iterative_divider #(.width(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .signed_i(signed_i),
      .dividend_i(dividend_i), .divisor_i(divisor_i), .busy_o(busy_o), .done_o(done_o),
      .quotient_o(quotient_o), .remainder_o(remainder_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic void chk(string n, logic [31:0] got, logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, got, want);
      end
   endfunction

   always @(negedge clk_i) begin
      exp_t e;
      if (rst_i) begin
         if (busy_o && done_o) begin
            bad++;
            $display("FAIL busy_and_done at cycle %0d", cyc);
         end
         if (done_o) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done at cycle %0d: got done_o=1 want none", cyc);
            end else begin
               e = sb.pop_front();
               chk({e.n, "_q"}, quotient_o, e.q);
               chk({e.n, "_r"}, remainder_o, e.r);
               chk({e.n, "_cycle"}, cyc, e.c);
            end
         end
      end
   end

   // Called at a negedge; the following posedge is the accepting edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic push, input logic [31:0] eq, input logic [31:0] er, input string n);
      dividend_i = a;
      divisor_i  = b;
      signed_i   = s;
      start_i    = 1'b1;
      if (push) sb.push_back('{eq, er, cyc + 34, n});
      @(negedge clk_i);
      start_i    = 1'b0;
      dividend_i = 32'hDEADBEEF;
      divisor_i  = 32'h3;
      signed_i   = ~s;
      chk({n, "_busy"}, {31'b0, busy_o}, 32'd1);
   endtask

   task automatic wait_done(input string n);
      for (int i = 0; i < 45; i++) begin
         if (done_o) return;
         @(negedge clk_i);
      end
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done_o within 45 cycles want done_o", n);
   endtask

   task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [31:0] eq, input logic [31:0] er, input string n);
      issue(a, b, s, 1'b1, eq, er, n);
      wait_done(n);
      @(negedge clk_i);
      @(negedge clk_i);
   endtask

   initial begin
      repeat (3) @(negedge clk_i);
      chk("rst_busy", {31'b0, busy_o}, 32'd0);
      chk("rst_done", {31'b0, done_o}, 32'd0);
      chk("rst_q", quotient_o, 32'd0);
      chk("rst_r", remainder_o, 32'd0);
      rst_i = 1'b1;
      @(negedge clk_i);
      run(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "u100_7");
`ifdef ITERATIVE_DIVIDER_SIGNED_EN
      run(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, "s_m7_2");
      run(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, "s_7_m2");
      run(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, "s_ovf");
`else
      run(32'hFFFFFFF9, 32'd2, 1'b1, 32'h7FFFFFFC, 32'd1, "s_m7_2");
      run(32'd7, 32'hFFFFFFFE, 1'b1, 32'd0, 32'd7, "s_7_m2");
      run(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 32'h80000000, "s_ovf");
`endif
      run(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, "u_ovf");
      run(32'h12345678, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678, "u_div0");
      run(32'hFFFFFFF9, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, "s_div0");
      issue(32'd1000, 32'd10, 1'b0, 1'b1, 32'd100, 32'd0, "ignore");
      repeat (9) @(negedge clk_i);
      start_i    = 1'b1;
      dividend_i = 32'd55;
      divisor_i  = 32'd5;
      @(negedge clk_i);
      start_i = 1'b0;
      wait_done("ignore");
      @(negedge clk_i);
      chk("ignore_idle", {31'b0, busy_o}, 32'd0);
      issue(32'hFFFFFFFF, 32'h10, 1'b0, 1'b1, 32'h0FFFFFFF, 32'hF, "b2b_a");
      wait_done("b2b_a");
      issue(32'd50, 32'd5, 1'b0, 1'b1, 32'd10, 32'd0, "b2b_b");
      wait_done("b2b_b");
      @(negedge clk_i);
      issue(32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0, "rst_run");
      repeat (13) @(negedge clk_i);
      #2 rst_i = 1'b0;
      #1;
      chk("midrst_busy", {31'b0, busy_o}, 32'd0);
      chk("midrst_done", {31'b0, done_o}, 32'd0);
      chk("midrst_q", quotient_o, 32'd0);
      chk("midrst_r", remainder_o, 32'd0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
      repeat (50) @(negedge clk_i);
      chk("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/iterative_divider.md
# iterative_divider

Multi-cycle restoring divider that performs integer division by repeated shift-and-subtract, one quotient bit per clock. It sits beside the ALU in the CPU datapath and serves the DIV/DIVU instructions, supplying the HI/LO values: remainder and quotient. It uses a start/busy/done handshake, so the controller stalls while `busy_o` is high.

## Interface
- `width`, 32: operand, quotient and remainder width in bits; minimum 2.
- `clk_i`  input  1  clock; all state changes on rising edge.
- `rst_i`  input  1  asynchronous, active-low reset.
- `start_i`  input  1  request; sampled on the rising edge only while `busy_o`=0.
- `signed_i`  input  1  1 = two's-complement operands (DIV), 0 = unsigned (DIVU); sampled with `start_i`.
- `dividend_i`  input  `width`  dividend; sampled with `start_i`.
- `divisor_i`  input  `width`  divisor; sampled with `start_i`.
- `busy_o`  output  1  high while the operation is in RUN or FIX.
- `done_o`  output  1  one-cycle pulse; results are valid from this cycle onward.
- `quotient_o`  output  `width`  registered quotient; holds until the next DONE.
- `remainder_o`  output  `width`  registered remainder; holds until the next DONE.

## Operation
- Reset asserted (`rst_i`=0): state goes to IDLE immediately. `busy_o`=0, `done_o`=0, `quotient_o`=0, `remainder_o`=0, and the internal iteration counter is cleared. Reset mid-operation aborts the division and discards the partial result.
- States and transitions:
  - IDLE → RUN on `start_i`=1.
  - RUN runs exactly `width` cycles, then → FIX.
  - FIX runs 1 cycle, then → DONE.
  - DONE runs 1 cycle, then → RUN if `start_i`=1 in that cycle, else → IDLE.
- Load, on the accepting edge:
  - Take operand magnitudes: when signed, negate each negative operand.
  - Record the quotient sign as the XOR of the operand sign bits, and the remainder sign as the dividend sign bit.
  - Clear the partial remainder. The counter loads `width`-1.
- RUN, each cycle:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Form a trial difference = partial remainder − divisor magnitude, computed at `width`+1 bits so the borrow is visible.
  - If there is no borrow, the partial remainder takes the difference and quotient bit = 1; otherwise quotient bit = 0.
  - The counter decrements.
- FIX:
  - Negate the quotient if its sign is set.
  - Negate the remainder if its sign is set and the remainder is nonzero.
  - Apply the special cases below.
- DONE: `quotient_o` and `remainder_o` were loaded on the edge entering DONE. `done_o`=1 for this cycle only.
- Divide by zero: `quotient_o` = all ones, `remainder_o` = the original `dividend_i`, for both signed and unsigned. Latency is unchanged.
- Signed overflow (most-negative value / −1): `quotient_o` = most-negative value, `remainder_o`=0.
- `start_i` during RUN or FIX is ignored; no queuing.
- Operands may change freely after the accepting edge.

## Timing
- `start_i` is sampled at edge E0.
- `busy_o`=1 from edge E0 through edge E0+`width`+1, i.e. covering RUN plus FIX.
- `done_o`=1 and results update at edge E0+`width`+1, and `done_o` falls at E0+`width`+2. For `width`=32, results appear 33 cycles after the start edge.
- Latency is fixed for all operand values, including zero divisor.
- Back-to-back operation: a new `start_i` in the DONE cycle begins the next division immediately. Throughput is one division per `width`+2 cycles.
- `busy_o` and `done_o` are never both 1.

## Configuration
- Macro `ITERATIVE_DIVIDER_SIGNED_EN`.
- Defined: `signed_i` is honoured; sign capture, operand negation, the FIX-stage result negation and the signed-overflow rule are compiled in.
- Undefined: the `signed_i` port remains but is ignored, and every operation is unsigned. The negation logic is removed. FIX still occupies one cycle, so timing is identical in both builds.

## Test plan
All scenarios use `width`=32.
- Unsigned 100 / 7: `start_i` with `signed_i`=0 → `done_o` exactly 33 cycles after the start edge, `quotient_o`=14, `remainder_o`=2.
- Signed −7 / 2 with the macro defined: `dividend_i`=0xFFFFFFF9, `divisor_i`=2 → `quotient_o`=0xFFFFFFFD, `remainder_o`=0xFFFFFFFF. With the macro undefined, same stimulus → `quotient_o`=0x7FFFFFFC, `remainder_o`=1.
- Divide by zero: 0x12345678 / 0 → `quotient_o`=0xFFFFFFFF, `remainder_o`=0x12345678, `done_o` still 33 cycles after start.
- Overflow, signed: 0x80000000 / 0xFFFFFFFF → `quotient_o`=0x80000000, `remainder_o`=0. Same operands unsigned → `quotient_o`=0, `remainder_o`=0x80000000.
- Handshake:
  - A `start_i` pulse at cycle 10 of RUN with different operands is ignored; the original result is delivered.
  - A `start_i` asserted in the DONE cycle is accepted, and the second `done_o` arrives 34 cycles after the first.
- Reset mid-RUN: assert `rst_i`=0 asynchronously at cycle 15 → `busy_o`, `done_o`, `quotient_o` and `remainder_o` drop to 0 without waiting for a clock edge, and no `done_o` follows after reset is released.
